// File: rtl/proc_test_sequencer.sv
// proc_test_sequencer: run-control and result checker for the single-cycle processor.
// Runs NUM_PROGS programs back to back. For each one it holds the core in reset with that
// program's start PC, releases it, waits for current_pc to reach the end PC (or a watchdog
// timeout), settles, then compares dmem_out against the expected word.
//
// Ports:
//   CLK, Reset_L             clock, synchronous active-low reset
//   start                    pulse to begin a run (ignored while busy)
//   prog_start_pc/_end_pc    packed per-program tables, program i at [i*XLEN +: XLEN]
//   prog_expected            packed expected dmem_out table, same packing
//   current_pc, dmem_out     observed core state
//   cpu_reset_l, cpu_start_pc  drive the core's reset and start PC
//   busy, done, all_passed   run status
//   cur_prog, pass_count     program index and number of passes this run
//   fail_mask, timeout_mask  per-program failure / watchdog flags
//   last_cycles              (only with SEQ_CYCLE_COUNT_EN) RUN cycles of the latest program
//
// Optional feature macro: SEQ_CYCLE_COUNT_EN.

module proc_test_sequencer #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned NUM_PROGS     = 4,
  parameter int unsigned IDX_W         = 2,
  parameter int unsigned RESET_CYCLES  = 1,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned WD_WIDTH      = 16
) (
  input  logic                      CLK,
  input  logic                      Reset_L,
  input  logic                      start,
  input  logic [NUM_PROGS*XLEN-1:0] prog_start_pc,
  input  logic [NUM_PROGS*XLEN-1:0] prog_end_pc,
  input  logic [NUM_PROGS*XLEN-1:0] prog_expected,
  input  logic [XLEN-1:0]           current_pc,
  input  logic [XLEN-1:0]           dmem_out,
  output logic                      cpu_reset_l,
  output logic [XLEN-1:0]           cpu_start_pc,
  output logic                      busy,
  output logic                      done,
  output logic                      all_passed,
  output logic [IDX_W-1:0]          cur_prog,
  output logic [7:0]                pass_count,
  output logic [NUM_PROGS-1:0]      fail_mask,
`ifdef SEQ_CYCLE_COUNT_EN
  output logic [NUM_PROGS-1:0]      timeout_mask,
  output logic [WD_WIDTH-1:0]       last_cycles
`else
  output logic [NUM_PROGS-1:0]      timeout_mask
`endif
);

  localparam int unsigned NumSlots = 2 ** IDX_W;

  typedef enum logic [2:0] {StIdle, StHold, StRun, StSettle, StCheck, StNext, StDone} state_e;

  state_e               state_q;
  logic [31:0]          cnt_q;
  logic [WD_WIDTH-1:0]  wd_q;
  logic [WD_WIDTH-1:0]  wd_inc;
  logic [NUM_PROGS-1:0] cur_bit;
  logic [IDX_W-1:0]     next_prog;

  // Tables padded to a power of two so cur_prog indexes them without width mismatch.
  logic [XLEN-1:0] start_tbl [NumSlots];
  logic [XLEN-1:0] end_tbl   [NumSlots];
  logic [XLEN-1:0] exp_tbl   [NumSlots];

  for (genvar i = 0; i < NumSlots; i++) begin : g_tbl
    if (i < NUM_PROGS) begin : g_used
      assign start_tbl[i] = prog_start_pc[i*XLEN +: XLEN];
      assign end_tbl[i]   = prog_end_pc[i*XLEN +: XLEN];
      assign exp_tbl[i]   = prog_expected[i*XLEN +: XLEN];
    end else begin : g_pad
      assign start_tbl[i] = '0;
      assign end_tbl[i]   = '0;
      assign exp_tbl[i]   = '0;
    end
  end

  assign wd_inc     = wd_q + WD_WIDTH'(1);
  assign cur_bit    = NUM_PROGS'(1) << cur_prog;
  assign next_prog  = cur_prog + IDX_W'(1);
  assign all_passed = done && (pass_count == 8'(NUM_PROGS));

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      wd_q         <= '0;
      cpu_reset_l  <= 1'b1;
      cpu_start_pc <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cur_prog     <= '0;
      pass_count   <= '0;
      fail_mask    <= '0;
      timeout_mask <= '0;
`ifdef SEQ_CYCLE_COUNT_EN
      last_cycles  <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            pass_count   <= '0;
            fail_mask    <= '0;
            timeout_mask <= '0;
            done         <= 1'b0;
            busy         <= 1'b1;
            cur_prog     <= '0;
            cpu_start_pc <= start_tbl[IDX_W'(0)];
            cpu_reset_l  <= 1'b0;
            cnt_q        <= '0;
            wd_q         <= '0;
            state_q      <= StHold;
          end
        end
        StHold: begin
          wd_q <= '0;
          if (cnt_q == RESET_CYCLES - 1) begin
            cpu_reset_l <= 1'b1;
            state_q     <= StRun;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StRun: begin
          // wd_inc counts RUN cycles including this one; end-PC match wins over timeout.
          wd_q <= wd_inc;
          if (current_pc >= end_tbl[cur_prog]) begin
            cnt_q   <= '0;
            state_q <= StSettle;
`ifdef SEQ_CYCLE_COUNT_EN
            last_cycles <= wd_inc;
`endif
          end else if (wd_inc == '1) begin
            fail_mask    <= fail_mask | cur_bit;
            timeout_mask <= timeout_mask | cur_bit;
            state_q      <= StNext;
`ifdef SEQ_CYCLE_COUNT_EN
            last_cycles  <= wd_inc;
`endif
          end
        end
        StSettle: begin
          if (cnt_q == SETTLE_CYCLES - 1) begin
            state_q <= StCheck;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StCheck: begin
          if (dmem_out == exp_tbl[cur_prog]) begin
            pass_count <= pass_count + 8'd1;
          end else begin
            fail_mask <= fail_mask | cur_bit;
          end
          state_q <= StNext;
        end
        StNext: begin
          if (cur_prog == IDX_W'(NUM_PROGS - 1)) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            cur_prog     <= next_prog;
            cpu_start_pc <= start_tbl[next_prog];
            cpu_reset_l  <= 1'b0;
            cnt_q        <= '0;
            state_q      <= StHold;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
